// File: rtl/parallel_to_serial_if.sv
// Bundle between the result serializer, the shared operand RAM read port and the UART transmitter.
// The master modport is the serializer's side of the bundle.
interface parallel_to_serial_if #(
    parameter int ABITS = 8,
    parameter int DBITS = 256
);
    logic             start;
    logic [ABITS-1:0] rd_addr;
    logic             rd_en;
    logic [DBITS-1:0] rd_data;
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, rd_data, tx_ready,
        output rd_addr, rd_en, tx_byte, tx_valid, busy, done
    );

    modport slave (
        output start, rd_data, tx_ready,
        input  rd_addr, rd_en, tx_byte, tx_valid, busy, done
    );
endinterface

// File: rtl/parallel_to_serial.sv
// Reads the N-bit RSA result word from RAM once and streams it to the UART
// one byte at a time, most significant byte first.
module parallel_to_serial #(
    parameter int N        = 32,
    parameter int Nlog2    = 5,
    parameter int ABITS    = 8,
    parameter int DBITS    = 256,
    parameter int RES_ADDR = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    parallel_to_serial_if.master bus
);
    localparam int NBYTES = N / 8;
    localparam logic [Nlog2-1:0] LAST_BYTE = Nlog2'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t           state_q;
    logic [N-1:0]     shift_q;
    logic [N-1:0]     shift_d;
    logic [Nlog2-1:0] cnt_q;
    logic [ABITS-1:0] rd_addr_q;
    logic             rd_en_q;
    logic [7:0]       tx_byte_q;
    logic             tx_valid_q;
    logic             done_q;

    // The byte after the current one is the top of the shifted word, which also covers N == 8.
    assign shift_d = shift_q << 8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= READ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= ABITS'(RES_ADDR);
                    end
                end
                READ: begin
                    state_q   <= CAPTURE;
                    rd_en_q   <= 1'b0;
                    rd_addr_q <= '0;
                end
                CAPTURE: begin
                    state_q    <= SEND;
                    shift_q    <= bus.rd_data[N-1:0];
                    cnt_q      <= '0;
                    tx_byte_q  <= bus.rd_data[N-1:N-8];
                    tx_valid_q <= 1'b1;
                end
                SEND: begin
                    if (tx_valid_q && bus.tx_ready) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + Nlog2'(1);
                        if (cnt_q == LAST_BYTE) begin
                            state_q    <= DONE;
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            tx_byte_q <= shift_d[N-1:N-8];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM bits above the result word carry other operands and are deliberately ignored.
    generate
        if (DBITS > N) begin : g_unused_hi
            logic unused_rd_hi;
            assign unused_rd_hi = ^bus.rd_data[DBITS-1:N];
        end
    endgenerate

    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.tx_byte  = tx_byte_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_parallel_to_serial.sv
// Randomized bench for parallel_to_serial: a RAM model with registered read,
// a negedge monitor, and a host-style reassembly reference.
module tb_parallel_to_serial;
    localparam int N        = 32;
    localparam int ABITS    = 8;
    localparam int DBITS    = 256;
    localparam int RES_ADDR = 4;
    localparam int NBYTES   = N / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parallel_to_serial_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

    parallel_to_serial #(
        .N(N), .Nlog2(5), .ABITS(ABITS), .DBITS(DBITS), .RES_ADDR(RES_ADDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DBITS-1:0] mem [0:(1<<ABITS)-1];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int checks   = 0;
    int failures = 0;

    logic [7:0] got [$];
    int   done_cnt, stab_err, rd_cycles, addr_err;
    logic pv, pr;
    logic [7:0] pb;
    bit   pat [$];

    // Monitor: records accepted bytes, done pulses, RAM reads and hold violations.
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr && (bus.tx_valid !== 1'b1 || bus.tx_byte !== pb)) stab_err++;
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) got.push_back(bus.tx_byte);
            if (bus.done === 1'b1) done_cnt++;
            if (bus.rd_en === 1'b1) begin
                rd_cycles++;
                if (bus.rd_addr !== ABITS'(RES_ADDR)) addr_err++;
            end
            pv = bus.tx_valid; pr = bus.tx_ready; pb = bus.tx_byte;
        end
    end

    // Reference: MSB byte first, as the host frames it.
    function automatic logic [7:0] exp_byte(input logic [N-1:0] w, input int i);
        return 8'((w >> (8 * (NBYTES - 1 - i))) & 'hFF);
    endfunction

    // Reference: host reassembly by shift-left-and-OR of whatever was accepted.
    function automatic logic [N-1:0] assemble();
        logic [N-1:0] w = '0;
        foreach (got[i]) w = (w << 8) | N'(got[i]);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        got.delete(); done_cnt = 0; stab_err = 0; rd_cycles = 0; addr_err = 0;
    endtask

    // mode 0: ready always 1; 1: ready from pat while valid; 2: random ready.
    task automatic run_xfer(input int mode, input int inj_cycle, input bit start_in_done,
                            input bit mutate, output bit timed_out);
        int pi = 0;
        clear_mon();
        bus.tx_ready = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            case (mode)
                0: bus.tx_ready = 1'b1;
                1: begin
                    if (bus.tx_valid) begin
                        bus.tx_ready = (pi < pat.size()) ? pat[pi] : 1'b1;
                        pi++;
                    end else bus.tx_ready = 1'b0;
                end
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
            bus.start = (c == inj_cycle);
            if (mutate && bus.tx_valid) mem[RES_ADDR] = {8{$urandom}};
            tick();
            if (bus.done) begin timed_out = 1'b0; break; end
        end
        bus.start = start_in_done;
        tick();
        bus.start = 1'b0;
        $display("xfer mode=%0d bytes=%0d word=%h done_pulses=%0d", mode, got.size(), assemble(), done_cnt);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.tx_ready = 1'b0;
        for (int i = 0; i < (1 << ABITS); i++) mem[i] = {8{$urandom}};
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({bus.tx_valid, bus.busy, bus.done, bus.rd_en} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got=%b required=0000", {bus.tx_valid, bus.busy, bus.done, bus.rd_en});
        end
        checks++;
        if (bus.rd_addr !== '0 || bus.tx_byte !== 8'h00) begin
            failures++; $display("FAIL reset_data addr=%h byte=%h required 0/00", bus.rd_addr, bus.tx_byte);
        end
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        tick(); tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release_idle busy=%b valid=%b required 0/0", bus.busy, bus.tx_valid);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] w = 32'hDEADBEEF;
        mem[RES_ADDR] = {{(DBITS-N){1'b1}}, w};
        clear_mon();
        bus.tx_ready = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== ABITS'(RES_ADDR) || bus.tx_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL basic_read rd_en=%b addr=%0d valid=%b busy=%b required 1/4/0/1", bus.rd_en, bus.rd_addr, bus.tx_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.rd_en !== 1'b0 || bus.tx_valid !== 1'b0) begin
            failures++; $display("FAIL basic_capture rd_en=%b valid=%b required 0/0", bus.rd_en, bus.tx_valid);
        end
        for (int i = 0; i < NBYTES; i++) begin
            tick();
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_byte !== exp_byte(w, i)) begin
                failures++; $display("FAIL basic_byte%0d valid=%b byte=%h required 1/%h", i, bus.tx_valid, bus.tx_byte, exp_byte(w, i));
            end
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.tx_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL basic_done done=%b valid=%b busy=%b required 1/0/1", bus.done, bus.tx_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL basic_idle done=%b busy=%b required 0/0", bus.done, bus.busy);
        end
        checks++;
        if (rd_cycles != 1 || addr_err != 0 || done_cnt != 1) begin
            failures++; $display("FAIL basic_counts reads=%0d addr_err=%0d done=%0d required 1/0/1", rd_cycles, addr_err, done_cnt);
        end
        $display("xfer basic bytes=%0d word=%h", got.size(), assemble());
    endtask

    task automatic test_backpressure();
        bit to;
        mem[RES_ADDR] = {{(DBITS-N){1'b0}}, 32'hDEADBEEF};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        run_xfer(1, -1, 1'b0, 1'b0, to);
        checks++;
        if (to || got.size() != NBYTES || assemble() !== 32'hDEADBEEF) begin
            failures++; $display("FAIL backpressure_stream timeout=%0b n=%0d word=%h required 0/4/deadbeef", to, got.size(), assemble());
        end
        checks++;
        if (stab_err != 0 || done_cnt != 1) begin
            failures++; $display("FAIL backpressure_hold stab_err=%0d done=%0d required 0/1", stab_err, done_cnt);
        end
    endtask

    task automatic test_start_busy();
        bit to;
        mem[RES_ADDR] = {{(DBITS-N){1'b0}}, 32'hDEADBEEF};
        run_xfer(0, 3, 1'b0, 1'b0, to);
        tick(); tick();
        checks++;
        if (to || got.size() != NBYTES || assemble() !== 32'hDEADBEEF || done_cnt != 1 || rd_cycles != 1) begin
            failures++; $display("FAIL start_busy n=%0d word=%h done=%0d reads=%0d required 4/deadbeef/1/1", got.size(), assemble(), done_cnt, rd_cycles);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL start_busy_idle busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit reached = 1'b0;
        logic [N-1:0] w2 = N'($urandom);
        mem[RES_ADDR] = {8{$urandom}};
        clear_mon();
        bus.tx_ready = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (got.size() >= 2) begin reached = 1'b1; break; end
        end
        checks++;
        if (!reached) begin
            failures++; $display("FAIL reset_mid_progress accepted=%0d required 2", got.size());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++; $display("FAIL reset_mid_abort valid=%b busy=%b done=%b required 0/0/0", bus.tx_valid, bus.busy, bus.done);
        end
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (done_cnt != 0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_nodone done=%0d busy=%b required 0/0", done_cnt, bus.busy);
        end
        mem[RES_ADDR] = {{(DBITS-N){1'b1}}, w2};
        run_xfer(0, -1, 1'b0, 1'b0, to);
        checks++;
        if (to || got.size() != NBYTES || assemble() !== w2 || done_cnt != 1) begin
            failures++; $display("FAIL reset_mid_restart n=%0d word=%h done=%0d required 4/%h/1", got.size(), assemble(), done_cnt, w2);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        mem[RES_ADDR] = {{(DBITS-N){1'b0}}, 32'hDEADBEEF};
        run_xfer(0, -1, 1'b1, 1'b0, to);
        checks++;
        if (to || assemble() !== 32'hDEADBEEF || bus.busy !== 1'b0) begin
            failures++; $display("FAIL b2b_first word=%h busy=%b required deadbeef/0", assemble(), bus.busy);
        end
        mem[RES_ADDR] = {{(DBITS-N){1'b0}}, 32'h00000001};
        run_xfer(0, -1, 1'b0, 1'b0, to);
        checks++;
        if (to || got.size() != NBYTES || got[0] !== 8'h00 || got[NBYTES-1] !== 8'h01 || assemble() !== 32'h00000001 || done_cnt != 1) begin
            failures++; $display("FAIL b2b_second n=%0d word=%h done=%0d required 4/00000001/1", got.size(), assemble(), done_cnt);
        end
    endtask

    task automatic test_random();
        bit to;
        logic [N-1:0] w;
        for (int it = 0; it < 25; it++) begin
            w = N'($urandom);
            mem[RES_ADDR] = {{7{$urandom}}, w};
            run_xfer(2, -1, 1'b0, 1'b1, to);
            checks++;
            if (to || got.size() != NBYTES || assemble() !== w) begin
                failures++; $display("FAIL random_word it=%0d timeout=%0b n=%0d word=%h required %h", it, to, got.size(), assemble(), w);
            end
            checks++;
            if (stab_err != 0 || done_cnt != 1 || rd_cycles != 1 || addr_err != 0) begin
                failures++; $display("FAIL random_proto it=%0d stab=%0d done=%0d reads=%0d addr_err=%0d required 0/1/1/0", it, stab_err, done_cnt, rd_cycles, addr_err);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.tx_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
